// File: rtl/bv_pkg.sv
// Shared definitions for the bit-vector builder: default geometry, state
// encoding and the counter-width helper.
package bv_pkg;

  localparam int unsigned WIDTH_DEFAULT       = 64;
  localparam int unsigned WIDTH_COUNT_DEFAULT = 6;

  typedef enum logic {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } state_t;

  // Bits needed to hold a count in the range 0..w inclusive.
  function automatic int unsigned count_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bv_set_bit.sv
// Combinational decode of one rule index: one-hot bit, range check and
// "already present in the accumulator" detection.
module bv_set_bit
  import bv_pkg::*;
#(
  parameter int unsigned width       = WIDTH_DEFAULT,
  parameter int unsigned width_count = WIDTH_COUNT_DEFAULT
) (
  input  logic [width_count-1:0] idx,
  input  logic [width-1:0]       acc,
  output logic [width-1:0]       onehot,
  output logic                   in_range,
  output logic                   already_set
);

  // When the index space exactly matches the vector every index is legal,
  // so no comparator is built at all.
  if (width < (2 ** width_count)) begin : g_range_check
    localparam logic [width_count-1:0] LIMIT = width_count'(width);
    assign in_range = (idx < LIMIT);
  end else begin : g_no_range_check
    assign in_range = 1'b1;
  end

  assign onehot      = in_range ? (width'(1) << idx) : '0;
  assign already_set = |(acc & onehot);

endmodule

// File: rtl/bv_build.sv
// Collects a stream of rule indices into one bit vector per packet and hands
// the vector plus hit/duplicate/range statistics to the downstream stage.
module bv_build
  import bv_pkg::*;
#(
  parameter int unsigned width       = WIDTH_DEFAULT,
  parameter int unsigned width_count = WIDTH_COUNT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   idx_valid,
  input  logic [width_count-1:0] idx,
  input  logic                   idx_null,
  input  logic                   idx_last,
  output logic                   idx_ready,
  output logic                   bv_out_valid,
  output logic [width-1:0]       bv_out,
  input  logic                   bv_out_ready,
  output logic [width_count:0]   hit_num,
  output logic                   dup_err,
  output logic                   range_err
);

  localparam int unsigned HIT_W = count_w(width);

  state_t             state, state_nxt;
  logic [width-1:0]   acc, acc_nxt;
  logic [HIT_W-1:0]   hit_acc, hit_acc_nxt;
  logic               dup_acc, dup_acc_nxt;
  logic               range_acc, range_acc_nxt;

  logic [width-1:0]   onehot;
  logic               in_range;
  logic               already_set;
  logic               accept;
  logic               show;

  bv_set_bit #(
    .width       (width),
    .width_count (width_count)
  ) u_set_bit (
    .idx         (idx),
    .acc         (acc),
    .onehot      (onehot),
    .in_range    (in_range),
    .already_set (already_set)
  );

  assign accept = idx_valid && (state == ACCUM);

  // NOTE: every variable gets its hold value first so that no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    hit_acc_nxt   = hit_acc;
    dup_acc_nxt   = dup_acc;
    range_acc_nxt = range_acc;
    unique case (state)
      ACCUM: begin
        if (accept) begin
          if (!idx_null) begin
            if (!in_range) begin
              range_acc_nxt = 1'b1;
            end else if (already_set) begin
              dup_acc_nxt = 1'b1;
            end else begin
              acc_nxt     = acc | onehot;
              hit_acc_nxt = hit_acc + HIT_W'(1);
            end
          end
          if (idx_last) state_nxt = OUT;
        end
      end
      OUT: begin
        if (bv_out_ready) begin
          state_nxt     = ACCUM;
          acc_nxt       = '0;
          hit_acc_nxt   = '0;
          dup_acc_nxt   = 1'b0;
          range_acc_nxt = 1'b0;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACCUM;
      acc       <= '0;
      hit_acc   <= '0;
      dup_acc   <= 1'b0;
      range_acc <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      hit_acc   <= hit_acc_nxt;
      dup_acc   <= dup_acc_nxt;
      range_acc <= range_acc_nxt;
    end
  end

  // Outputs are forced low while reset is held; the accumulator is only
  // visible once the vector is complete.
  assign idx_ready    = !reset && (state == ACCUM);
  assign show         = !reset && (state == OUT);
  assign bv_out_valid = show;
  assign bv_out       = show ? acc : '0;
  assign hit_num      = show ? (width_count + 1)'(hit_acc) : '0;
  assign dup_err      = show && dup_acc;
  assign range_err    = show && range_acc;

endmodule
